// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared definitions for the byte-level I2C master: command
//               encodings, controller state and quarter-phase enums, and the
//               helper that selects the SDA level for each of the 9 bit slots.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_STOP  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_READ  = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_STOP, ST_BIT} state_t;
   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_t;

   // SDA drive level for bit slot idx (0..7 data MSB first, 8 = ACK slot).
   // WRITE: data bits, then release for the slave's ACK.
   // READ : release for the slave's data, then drive our ACK/NACK.
   function automatic logic bit_sda(input logic [1:0] cmd,
                                    input logic [7:0] data,
                                    input logic       ack,
                                    input logic [3:0] idx);
      logic [2:0] pos;
      pos = 3'd7 - idx[2:0];
      if (idx == 4'd8) return (cmd == CMD_WRITE) ? 1'b1 : ~ack;
      return (cmd == CMD_WRITE) ? data[pos] : 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_timer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_quarter_timer
// Description : Quarter-SCL-period down counter. Reloads CLOCKS_PER_QUARTER-1
//               on restart, otherwise decrements; o_tick flags a zero count.
//               While i_hold is set and the counter still sits at its load
//               value the count is frozen, so a stretched phase starts
//               counting only once the hold clears.
// Ports       : i_clk     - system clock
//               i_reset   - synchronous active-high reset (count -> 0)
//               i_restart - reload the quarter count
//               i_hold    - freeze a freshly loaded count
//               o_tick    - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_quarter_timer #(
   parameter int CLOCKS_PER_QUARTER = 90,
   parameter int CW                 = 8
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_restart,
   input  logic i_hold,
   output logic o_tick
);

   localparam logic [CW-1:0] LOAD = CW'(CLOCKS_PER_QUARTER - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q - CW'(1);
      if (i_restart)
         cnt_d = LOAD;
      else if (i_hold && (cnt_q == LOAD))
         cnt_d = cnt_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign o_tick = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : i2c_byte_master
// Description : Byte-level I2C bus master producing START, STOP, byte WRITE
//               and byte READ waveforms. Drives open-drain pad wrapper data
//               inputs (1 = release, 0 = pull low) and reads the pin sense
//               back for ACK/data sampling.
// Config      : I2C_CLOCK_STRETCH_EN - when defined, a phase that releases
//               SCL does not start counting until the SCL pin reads high.
// Ports       : i_clk, i_reset            - clock, sync active-high reset
//               i_cmd_stb, i_cmd, i_data,
//               i_ack                     - command interface
//               o_busy, o_done            - status / completion pulse
//               o_data, o_ack_rcvd        - READ byte, WRITE ACK result
//               o_scl, o_sda              - to pad wrapper data inputs
//               i_scl, i_sda              - pad pin sense
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_master
   import i2c_pkg::*;
#(
   parameter int CLOCKS_PER_QUARTER = 90,
   parameter int CW                 = 8
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_cmd_stb,
   input  logic [1:0] i_cmd,
   input  logic [7:0] i_data,
   input  logic       i_ack,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_data,
   output logic       o_ack_rcvd,
   output logic       o_scl,
   output logic       o_sda,
   input  logic       i_scl,
   input  logic       i_sda
);

   state_t     state_q;
   phase_t     phase_q;
   logic [1:0] cmd_q;
   logic [7:0] tx_q;
   logic [7:0] rx_q;
   logic       ack_q;
   logic [3:0] bit_q;
   logic       busy_q;
   logic       done_q;
   logic [7:0] data_q;
   logic       ack_rcvd_q;
   logic       scl_q;
   logic       sda_q;

   logic w_accept;
   logic w_tick_raw;
   logic w_tick;
   logic w_hold;
   logic w_last;

   assign w_accept = i_cmd_stb && !busy_q;
   assign w_tick   = busy_q && w_tick_raw;
   // Final quarter of the command: Q3 of START/STOP, or Q3 of the ACK slot.
   assign w_last   = w_tick && (phase_q == Q3) &&
                     ((state_q != ST_BIT) || (bit_q == 4'd8));

`ifdef I2C_CLOCK_STRETCH_EN
   // SCL released but still low on the pin: a slave is stretching.
   assign w_hold = scl_q && !i_scl;
`else
   logic w_unused_scl;
   assign w_hold       = 1'b0;
   assign w_unused_scl = i_scl;
`endif

   i2c_quarter_timer #(
      .CLOCKS_PER_QUARTER (CLOCKS_PER_QUARTER),
      .CW                 (CW)
   ) u_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_restart (w_accept || w_tick),
      .i_hold    (w_hold),
      .o_tick    (w_tick_raw)
   );

   // Each assignment below sets the line levels for the phase being entered.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         phase_q    <= Q0;
         cmd_q      <= CMD_START;
         tx_q       <= '0;
         rx_q       <= '0;
         ack_q      <= 1'b0;
         bit_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         data_q     <= '0;
         ack_rcvd_q <= 1'b0;
         scl_q      <= 1'b1;
         sda_q      <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (w_accept) begin
            busy_q  <= 1'b1;
            cmd_q   <= i_cmd;
            tx_q    <= i_data;
            ack_q   <= i_ack;
            bit_q   <= '0;
            phase_q <= Q0;
            case (i_cmd)
               CMD_START: begin
                  state_q <= ST_START;
                  sda_q   <= 1'b1;
               end
               CMD_STOP: begin
                  state_q <= ST_STOP;
                  scl_q   <= 1'b0;
                  sda_q   <= 1'b0;
               end
               default: begin
                  state_q <= ST_BIT;
                  scl_q   <= 1'b0;
                  sda_q   <= bit_sda(i_cmd, i_data, i_ack, 4'd0);
               end
            endcase
         end else if (w_tick) begin
            phase_q <= phase_t'(phase_q + 2'd1);
            case (state_q)
               ST_START: begin
                  case (phase_q)
                     Q0:      scl_q <= 1'b1;
                     Q1:      sda_q <= 1'b0;
                     Q2:      scl_q <= 1'b0;
                     default: ;
                  endcase
               end
               ST_STOP: begin
                  case (phase_q)
                     Q0:      scl_q <= 1'b1;
                     Q1:      sda_q <= 1'b1;
                     default: ;
                  endcase
               end
               ST_BIT: begin
                  case (phase_q)
                     Q0: scl_q <= 1'b1;
                     Q2: begin
                        scl_q <= 1'b0;
                        if (bit_q == 4'd8) begin
                           if (cmd_q == CMD_WRITE)
                              ack_rcvd_q <= ~i_sda;
                        end else begin
                           rx_q <= {rx_q[6:0], i_sda};
                        end
                     end
                     Q3: begin
                        if (bit_q != 4'd8) begin
                           bit_q <= bit_q + 4'd1;
                           sda_q <= bit_sda(cmd_q, tx_q, ack_q, bit_q + 4'd1);
                        end
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
            if (w_last) begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
               if ((state_q == ST_BIT) && (cmd_q == CMD_READ))
                  data_q <= rx_q;
            end
         end
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_data     = data_q;
   assign o_ack_rcvd = ack_rcvd_q;
   assign o_scl      = scl_q;
   assign o_sda      = sda_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_byte_master
// Description : Scoreboard bench for i2c_byte_master. A driver issues
//               commands and pushes the expected completion into a queue; a
//               monitor pops and compares on every o_done. A simple slave
//               model drives SDA (ACK or read data) and can stretch SCL.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_master;

   localparam int CPQ = 4;
`ifdef I2C_CLOCK_STRETCH_EN
   localparam int STRETCH_EXTRA = 20;
`else
   localparam int STRETCH_EXTRA = 0;
`endif
   localparam logic [1:0] C_START = 2'b00;
   localparam logic [1:0] C_STOP  = 2'b01;
   localparam logic [1:0] C_WRITE = 2'b10;
   localparam logic [1:0] C_READ  = 2'b11;
   localparam int SM_NONE = 0;
   localparam int SM_ACK  = 1;
   localparam int SM_READ = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       stb;
   logic [1:0] cmd;
   logic [7:0] din;
   logic       ack_in;
   logic       busy, done, ackr, oscl, osda;
   logic [7:0] dout;
   logic       bus_scl, bus_sda;
   logic       stretch;
   logic       slave_sda;

   always #5 clk = ~clk;

   assign bus_scl = oscl & ~stretch;
   assign bus_sda = osda & slave_sda;

   i2c_byte_master #(.CLOCKS_PER_QUARTER(CPQ), .CW(4)) dut (
      .i_clk(clk), .i_reset(rst), .i_cmd_stb(stb), .i_cmd(cmd),
      .i_data(din), .i_ack(ack_in), .o_busy(busy), .o_done(done),
      .o_data(dout), .o_ack_rcvd(ackr), .o_scl(oscl), .o_sda(osda),
      .i_scl(bus_scl), .i_sda(bus_sda));

   typedef struct {
      logic [1:0] cmd;
      int         acc;
      int         lat;
      logic [7:0] data;
      logic       ack;
      logic [8:0] pat;
   } sb_t;
   sb_t sb[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [7:0] model_data = 8'h00;
   logic       model_ack  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- slave model: bit slot = SCL falls since accept --------
   int         falls = 0;
   logic       prev_scl = 1'b1;
   int         pend_mode = SM_NONE, cur_mode = SM_NONE;
   logic [7:0] pend_byte = 8'h00, cur_byte = 8'h00;

   always @(posedge clk) begin
      if (stb && !busy && !rst) begin
         falls    <= oscl ? -1 : 0;
         cur_mode <= pend_mode;
         cur_byte <= pend_byte;
      end else if (prev_scl && !oscl) begin
         falls <= falls + 1;
      end
      prev_scl <= oscl;
   end

   always_comb begin
      slave_sda = 1'b1;
      if (cur_mode == SM_ACK && falls == 8) slave_sda = 1'b0;
      if (cur_mode == SM_READ && falls >= 0 && falls < 8) slave_sda = cur_byte[7-falls];
   end

   // ---------------- bus monitor and scoreboard checker --------------------
   int         n_start = 0, n_stop = 0, nbits = 0;
   logic [8:0] pat = '0;
   logic       p_bscl = 1'b1, p_bsda = 1'b1, p_oscl = 1'b1, p_osda = 1'b1;

   always @(negedge clk) begin
      sb_t it;
      if (!rst) begin
         if (p_bscl && bus_scl && p_bsda && !bus_sda) n_start++;
         if (p_bscl && bus_scl && !p_bsda && bus_sda) n_stop++;
         if (p_oscl && !oscl) begin
            pat = {pat[7:0], p_osda};
            nbits++;
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               it = sb.pop_front();
               chk("latency", 32'(cyc - it.acc + 1), 32'(it.lat));
               chk("busy_at_done", 32'(busy), 32'd0);
               chk("o_data", 32'(dout), 32'(it.data));
               chk("o_ack_rcvd", 32'(ackr), 32'(it.ack));
               if (it.cmd == C_WRITE || it.cmd == C_READ) begin
                  chk("sda_bits", {19'd0, 4'(nbits), pat}, {19'd0, 4'd9, it.pat});
                  chk("no_start_stop_in_byte", 32'(n_start + n_stop), 32'd0);
               end else if (it.cmd == C_START) begin
                  chk("start_cond", 32'(n_start), 32'd1);
               end else begin
                  chk("stop_cond", 32'(n_stop), 32'd1);
                  chk("idle_lines", {30'd0, oscl, osda}, 32'd3);
               end
            end
         end
      end
      p_bscl = bus_scl; p_bsda = bus_sda; p_oscl = oscl; p_osda = osda;
   end

   // ---------------- driver -------------------------------------------------
   task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a,
                        input int smode, input logic [7:0] sbyte,
                        input bit do_stretch, input bit inject);
      sb_t  it;
      int   n;
      int   rises;
      logic last;
      @(negedge clk);
      n = 0;
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", 32'(busy), 32'd0);
      stb = 1'b1; cmd = c; din = d; ack_in = a;
      pend_mode = smode; pend_byte = sbyte;
      @(posedge clk);
      #1;
      stb = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
      n_start = 0; n_stop = 0; nbits = 0; pat = '0;
      it.cmd = c;
      it.acc = cyc;
      it.lat = ((c == C_START || c == C_STOP) ? 4 * CPQ : 36 * CPQ) + 1
               + (do_stretch ? STRETCH_EXTRA : 0);
      it.pat = '1;
      if (c == C_READ) begin
         model_data = (smode == SM_READ) ? sbyte : 8'hFF;
         it.pat = {8'hFF, ~a};
      end
      if (c == C_WRITE) begin
         model_ack = (smode == SM_ACK);
         it.pat = {d, 1'b1};
      end
      it.data = model_data;
      it.ack  = model_ack;
      sb.push_back(it);
      if (inject) begin
         repeat (20) @(negedge clk);
         stb = 1'b1; cmd = C_READ; din = 8'hFF; ack_in = 1'b1;
         @(negedge clk);
         stb = 1'b0;
      end
      if (do_stretch) begin
         rises = 0;
         last  = oscl;
         n     = 0;
         while (rises < 4 && n < 2000) begin
            @(posedge clk);
            #1;
            if (oscl && !last) rises++;
            last = oscl;
            n++;
         end
         chk("stretch_found_bit3", 32'(rises), 32'd4);
         stretch = 1'b1;
         repeat (20) @(posedge clk);
         #1;
         stretch = 1'b0;
      end
   endtask

   task automatic reset_mid_write();
      issue(C_WRITE, 8'h5A, 1'b0, SM_ACK, 8'h00, 1'b0, 1'b0);
      repeat (16 * CPQ + 2) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      model_data = 8'h00;
      model_ack  = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_scl", 32'(oscl), 32'd1);
      chk("rst_mid_sda", 32'(osda), 32'd1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int n;
      logic [1:0] rc;
      rst = 1'b1; stb = 1'b0; cmd = 2'b00; din = 8'h00; ack_in = 1'b0;
      stretch = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_scl", 32'(oscl), 32'd1);
      chk("rst_sda", 32'(osda), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_data", 32'(dout), 32'd0);
      chk("rst_ack_rcvd", 32'(ackr), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed sequence
      issue(C_START, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b0, 1'b0);
      issue(C_WRITE, 8'hA5, 1'b0, SM_ACK,  8'h00, 1'b0, 1'b0);
      issue(C_READ,  8'h00, 1'b0, SM_READ, 8'h3C, 1'b0, 1'b0);
      issue(C_WRITE, 8'h96, 1'b0, SM_NONE, 8'h00, 1'b0, 1'b0);
      issue(C_STOP,  8'h00, 1'b0, SM_NONE, 8'h00, 1'b0, 1'b0);

      // Randomised bytes
      issue(C_START, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         rc = ($urandom_range(0, 1) == 0) ? C_WRITE : C_READ;
         if (rc == C_WRITE)
            issue(C_WRITE, 8'($urandom), 1'b0, int'($urandom_range(0, 1)), 8'h00, 1'b0, 1'b0);
         else
            issue(C_READ, 8'h00, 1'($urandom), ($urandom_range(0, 3) == 0) ? SM_NONE : SM_READ,
                  8'($urandom), 1'b0, 1'b0);
      end
      issue(C_STOP, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b0, 1'b0);

      // Strobe while busy is ignored
      issue(C_START, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b0, 1'b0);
      issue(C_WRITE, 8'hC3, 1'b0, SM_ACK,  8'h00, 1'b0, 1'b1);

      // Reset in the middle of a byte, then a normal START
      reset_mid_write();
      issue(C_START, 8'h00, 1'b0, SM_NONE, 8'h00, 1'b0, 1'b0);

      // SCL held low by the slave during bit 3 Q1
      issue(C_WRITE, 8'h71, 1'b0, SM_ACK,  8'h00, 1'b1, 1'b0);
      issue(C_STOP,  8'h00, 1'b0, SM_NONE, 8'h00, 1'b0, 1'b0);

      n = 0;
      while (sb.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Byte-level I2C bus master that generates SCL/SDA waveforms for START, STOP, byte WRITE and byte READ commands.
- Sits directly upstream of the open-drain pad wrappers, one per line (SCL, SDA).
- Drives each wrapper's data input: 1 releases the line, 0 pulls it low.
- Reads the wrapper's pin-sense output back for ACK/data sampling and clock stretching.

Parameters:
- CLOCKS_PER_QUARTER, 90, system clocks per quarter SCL period (36 MHz → 100 kHz); must be ≥2.
- CW, 8, quarter-counter width; must hold CLOCKS_PER_QUARTER-1.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_cmd_stb  in  1  command valid; accepted only when !o_busy
- i_cmd  in  2  command: 00 START, 01 STOP, 10 WRITE, 11 READ
- i_data  in  8  byte to transmit (WRITE)
- i_ack  in  1  READ only: 1 = master ACKs (drives SDA low on bit 9), 0 = NACK
- o_busy  out  1  command in progress
- o_done  out  1  one-cycle completion pulse
- o_data  out  8  byte received (READ); held until the next READ completes
- o_ack_rcvd  out  1  WRITE: 1 if slave pulled SDA low on bit 9
- o_scl  out  1  to SCL pad wrapper data input (1 = release)
- o_sda  out  1  to SDA pad wrapper data input (1 = release)
- i_scl  in  1  SCL pin sense from pad wrapper
- i_sda  in  1  SDA pin sense from pad wrapper

Behaviour:
- Reset values: o_scl=1, o_sda=1, o_busy=0, o_done=0, o_data=0, o_ack_rcvd=0, state IDLE, counter 0.
- Reset wins over every other event, including mid-command; lines are released the cycle after reset is sampled.
- Quarter timer:
  - Loads CLOCKS_PER_QUARTER-1 on command accept and after each tick; decrements otherwise.
  - tick = counter==0 while busy.
- States: IDLE, START, STOP, BIT. Each state advances one quarter phase (Q0..Q3) per tick.
- Accept: i_cmd_stb && !o_busy. Latch cmd, i_data, i_ack; o_busy=1 on the next cycle.
  - Strobes while busy are ignored; no queueing.
  - No bus-state tracking: WRITE/READ without a prior START still executes.
- START:
  - Q0: sda=1, scl held.
  - Q1: scl=1.
  - Q2: sda=0.
  - Q3: scl=0.
  - Covers both idle and repeated start.
- STOP:
  - Q0: scl=0, sda=0.
  - Q1: scl=1.
  - Q2: sda=1.
  - Q3: hold.
- BIT: 9 bits; bit counter counts 0..8; data is MSB first.
  - Q0: scl=0, set sda.
  - Q1: scl=1.
  - Q2: scl=1; sample i_sda at the Q2 tick.
  - Q3: scl=0.
- WRITE:
  - Bits 0-7: sda=data bit.
  - Bit 8: sda=1; o_ack_rcvd = !sample.
- READ:
  - Bits 0-7: sda=1; samples shifted into the receive register.
  - Bit 8: sda = !i_ack.
  - o_data updated at completion.
- Completion: at the final Q3 tick, the next cycle has o_busy=0 and o_done=1 for exactly one cycle.
  - A new command may be accepted on the o_done cycle.
- Latency, accept to o_done (without stretching):
  - START/STOP: 4·CLOCKS_PER_QUARTER+1 cycles.
  - WRITE/READ: 36·CLOCKS_PER_QUARTER+1 cycles.
- SCL transitions only on tick boundaries.
- SDA changes only while scl=0, except the START/STOP edges.

Optional Feature:
- Macro I2C_CLOCK_STRETCH_EN.
- Defined: after any phase that releases SCL (o_scl=1), the counter holds at its load value while i_scl==0. The quarter starts counting only once i_scl reads 1, so slave stretching extends the phase cycle-for-cycle.
- Undefined: i_scl is unused and phases are fixed length.

Decomposition:
- Shared package i2c_pkg:
  - Command encodings CMD_START/CMD_STOP/CMD_WRITE/CMD_READ.
  - State enum IDLE/START/STOP/BIT.
  - Phase encoding Q0..Q3.
- One natural sub-module, i2c_quarter_timer:
  - Counter, tick, and stretch hold.
  - Ports: i_clk, i_reset, i_restart, i_hold, o_tick.

Test Plan (CLOCKS_PER_QUARTER=4):
- START from reset, then WRITE 0xA5 with slave model pulling SDA low on bit 9:
  - START: SDA falls while SCL=1.
  - SDA at the Q2 samples: 1,0,1,0,0,1,0,1,then released.
  - o_ack_rcvd=1; o_done 145 cycles after WRITE accept.
- READ with i_ack=0 and slave driving 0x3C:
  - o_data=0x3C at o_done.
  - o_sda=1 throughout all 9 bits.
  - WRITE with no slave → o_ack_rcvd=0.
- STOP after a byte:
  - SCL rises while SDA=0, then SDA rises while SCL=1.
  - Idle lines both 1; o_done pulses once, 17 cycles after accept.
- Assert i_reset at bit 4 of a WRITE:
  - Next cycle o_scl=1, o_sda=1, o_busy=0, no o_done.
  - A subsequent START executes normally.
- Issue i_cmd_stb with READ while a WRITE is busy:
  - Ignored; exactly one o_done.
  - o_data unchanged.
- Hold i_scl=0 for 20 cycles during bit 3 Q1:
  - With I2C_CLOCK_STRETCH_EN, o_done is delayed by 20 cycles versus baseline.
  - Without it, timing is unchanged.
